// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID-side inputs and EX-side outputs of the ID/EX register
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              stall_i;
  logic              flush_i;
  logic [1:0]        ID_WB_i;
  logic [1:0]        ID_M_i;
  logic [3:0]        ID_EX_i;
  logic [DATA_W-1:0] ID_RSdata_i;
  logic [DATA_W-1:0] ID_RTdata_i;
  logic [DATA_W-1:0] ID_imm_i;
  logic [4:0]        ID_RSaddr_i;
  logic [4:0]        ID_RTaddr_i;
  logic [4:0]        ID_RDaddr_i;
  logic [1:0]        WB_o;
  logic [1:0]        M_o;
  logic [3:0]        EX_o;
  logic [DATA_W-1:0] RSdata_o;
  logic [DATA_W-1:0] RTdata_o;
  logic [DATA_W-1:0] imm_o;
  logic [4:0]        RSaddr_o;
  logic [4:0]        RTaddr_o;
  logic [4:0]        RDaddr_o;
  logic              valid_o;
  logic              hazard_o;
  logic [CNT_W-1:0]  bubble_cnt_o;
  logic [CNT_W-1:0]  flush_cnt_o;

  modport slave (
    input  stall_i, flush_i, ID_WB_i, ID_M_i, ID_EX_i, ID_RSdata_i, ID_RTdata_i,
           ID_imm_i, ID_RSaddr_i, ID_RTaddr_i, ID_RDaddr_i,
    output WB_o, M_o, EX_o, RSdata_o, RTdata_o, imm_o, RSaddr_o, RTaddr_o,
           RDaddr_o, valid_o, hazard_o, bubble_cnt_o, flush_cnt_o
  );

  modport master (
    output stall_i, flush_i, ID_WB_i, ID_M_i, ID_EX_i, ID_RSdata_i, ID_RTdata_i,
           ID_imm_i, ID_RSaddr_i, ID_RTaddr_i, ID_RDaddr_i,
    input  WB_o, M_o, EX_o, RSdata_o, RTdata_o, imm_o, RSaddr_o, RTaddr_o,
           RDaddr_o, valid_o, hazard_o, bubble_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble insertion
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  id_ex_stage_if.slave bus
);
  logic [1:0]        r_wb;
  logic [1:0]        r_m;
  logic [3:0]        r_ex;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [4:0]        r_rs_addr;
  logic [4:0]        r_rt_addr;
  logic [4:0]        r_rd_addr;
  logic              r_valid;
  logic [CNT_W-1:0]  r_bubble_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic              w_lu;
  logic              w_bubble;

  // A load in EX whose destination is read by the instruction in ID; $zero never counts.
  assign w_lu = r_m[0] & r_valid & (r_rt_addr != 5'd0) &
                ((r_rt_addr == bus.ID_RSaddr_i) | (r_rt_addr == bus.ID_RTaddr_i));
  assign w_bubble = bus.flush_i | w_lu;

  assign bus.hazard_o     = w_lu & ~bus.flush_i;
  assign bus.WB_o         = r_wb;
  assign bus.M_o          = r_m;
  assign bus.EX_o         = r_ex;
  assign bus.RSdata_o     = r_rs_data;
  assign bus.RTdata_o     = r_rt_data;
  assign bus.imm_o        = r_imm;
  assign bus.RSaddr_o     = r_rs_addr;
  assign bus.RTaddr_o     = r_rt_addr;
  assign bus.RDaddr_o     = r_rd_addr;
  assign bus.valid_o      = r_valid;
  assign bus.bubble_cnt_o = r_bubble_cnt;
  assign bus.flush_cnt_o  = r_flush_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wb         <= '0;
      r_m          <= '0;
      r_ex         <= '0;
      r_rs_data    <= '0;
      r_rt_data    <= '0;
      r_imm        <= '0;
      r_rs_addr    <= '0;
      r_rt_addr    <= '0;
      r_rd_addr    <= '0;
      r_valid      <= 1'b0;
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else if (!bus.stall_i) begin
      r_rs_data <= bus.ID_RSdata_i;
      r_rt_data <= bus.ID_RTdata_i;
      r_imm     <= bus.ID_imm_i;
      r_rs_addr <= bus.ID_RSaddr_i;
      r_rt_addr <= bus.ID_RTaddr_i;
      r_rd_addr <= bus.ID_RDaddr_i;
      // Bubbles zero every control bit so nothing downstream writes or forwards.
      if (w_bubble) begin
        r_wb    <= '0;
        r_m     <= '0;
        r_ex    <= '0;
        r_valid <= 1'b0;
      end else begin
        r_wb    <= bus.ID_WB_i;
        r_m     <= bus.ID_M_i;
        r_ex    <= bus.ID_EX_i;
        r_valid <= 1'b1;
      end
      if (bus.flush_i) begin
        if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 1'b1;
      end else if (w_lu) begin
        if (r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end
    end
  end
endmodule
